serial_bit_feeder: RTL and testbench
====================================

// Module: serial_bit_feeder
// PURPOSE
//  Upstream stage of the serial sequence-detector FSM. Buffers parallel words from a producer over a
//  valid/ready handshake and emits them as a continuous one-bit-per-clock stream on sout.
//  sout drives the detector's serial input directly. Idle cycles carry IDLE_BIT.
//  Back-to-back words are emitted with no gap bits.
// PARAMETERS
//  WIDTH     8   bits per parallel word (>=2)
//  DEPTH     4   word buffer entries (power of two, >=2)
//  IDLE_BIT  0   value driven on sout when no word is being shifted
//  MSB_FIRST 1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//  clk        in   1                  rising-edge clock
//  rst        in   1                  synchronous, active-high reset
//  din        in   WIDTH              parallel word from producer
//  din_valid  in   1                  din holds a word
//  din_ready  out  1                  buffer can accept; transfer when din_valid & din_ready at clk edge
//  sout       out  1                  serial bit to detector (registered)
//  sout_valid out  1                  sout carries a data bit this cycle (registered)
//  word_done  out  1                  1-cycle pulse, high while the last bit of a word is on sout
//  level      out  $clog2(DEPTH)+1    words currently buffered (excludes the word in the shifter)
// BEHAVIOUR
//  Reset: clk edge with rst=1 clears buffer pointers, level=0, state=IDLE, bit counter=0.
//   It also sets sout=IDLE_BIT, sout_valid=0, word_done=0. din_ready=0 while rst=1.
//   Reset mid-word drops the partially shifted word and all buffered words. Nothing resumes.
//  Handshake: din_ready = !rst & (level < DEPTH), from registered level only (no comb path from outputs).
//   A pop in the same cycle does not raise din_ready; the slot frees one cycle later.
//   din is ignored when din_ready=0.
//  Buffer: first-word-fall-through. The head word is readable combinationally whenever level>0.
//   Simultaneous push and pop leaves level unchanged. Pointers wrap modulo DEPTH.
//  FSM states (registered):
//   IDLE:  sout=IDLE_BIT, sout_valid=0. If level>0 at the edge: pop head, load shifter,
//          drive first bit on sout, sout_valid=1, bitcnt=WIDTH-1, go to SHIFT.
//   SHIFT: each edge shift the next bit onto sout and decrement bitcnt.
//          word_done=1 while bitcnt==0, i.e. while the last bit is on sout.
//          At the edge ending that cycle:
//            level>0  -> pop, load next word, stay in SHIFT (no gap bit)
//            level==0 -> go to IDLE: sout=IDLE_BIT, sout_valid=0
//  Latency: word accepted at edge E0 into an empty, idle block -> first bit on sout in the cycle after E1.
//   The word occupies WIDTH consecutive cycles.
//  Bit order: MSB_FIRST=1 shifts left and sends din[WIDTH-1] first; MSB_FIRST=0 sends din[0] first.
//  Capacity: DEPTH words buffered plus 1 word in the shifter.
// STRUCTURE
//  Shared package serial_feeder_pkg:
//   state enum {ST_IDLE, ST_SHIFT}
//   localparam functions/constants for bit-counter width ($clog2(WIDTH)) and level width
//  One sub-module: sync_fifo_fwft (WIDTH x DEPTH, push/pop/level/full/empty).
//  Top holds the FSM, shifter, bit counter and output registers.
// TESTING
//  1 Reset: rst=1 for 2 cycles, din_valid=1
//     -> din_ready=0, sout=0, sout_valid=0, level=0; after release din_ready=1, nothing accepted.
//  2 Single word: push 8'hB0 at edge E0
//     -> cycles 2..9 sout=1,0,1,1,0,0,0,0 with sout_valid=1; word_done only in cycle 9;
//        cycle 10 sout=0, sout_valid=0. Downstream detector flags the 1011.
//  3 Back-to-back: push 8'hA5,8'h3C,8'hFF,8'h01 on consecutive cycles
//     -> 32 contiguous valid bits in order, no idle gap, word_done every 8th cycle.
//  4 Full: hold din_valid=1 with incrementing words
//     -> level reaches 4, din_ready drops; scoreboard shows no word lost or duplicated,
//        din_ready rises one cycle after each pop.
//  5 Reset mid-word: assert rst after 3 bits of 8'hF0 with 2 words buffered
//     -> next cycle sout=0, sout_valid=0, level=0; a new word 8'h0F afterwards streams cleanly.
//  6 MSB_FIRST=0, push 8'h0D
//     -> sout=1,0,1,1,0,0,0,0.

Source files
------------

// File: rtl/serial_feeder_pkg.sv
// Shared types and width helpers for the serial bit feeder and its word buffer.
package serial_feeder_pkg;

   typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

   function automatic int unsigned cnt_width(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head word visible on dout whenever not empty.
module sync_fifo_fwft
   import serial_feeder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned LVL_W = level_width(DEPTH),
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push, do_pop;

   assign full    = (level_q == LVL_W'(DEPTH));
   assign empty   = (level_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem_q[rptr_q];
   assign level   = level_q;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap
   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (do_push) begin
         mem_d[wptr_q] = din;
         wptr_d        = wptr_q + 1'b1;
      end
      if (do_pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/serial_bit_feeder.sv
// Buffers parallel words and streams them one bit per clock on sout, back-to-back with no gap bits.
module serial_bit_feeder
   import serial_feeder_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 4,
   parameter logic        IDLE_BIT  = 1'b0,
   parameter bit          MSB_FIRST = 1'b1,
   localparam int unsigned LVL_W    = level_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             word_done,
   output logic [LVL_W-1:0] level
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
   logic             sout_q, sout_d;
   logic             sout_valid_q, sout_valid_d;
   logic             word_done_q, word_done_d;

   logic [WIDTH-1:0] head, head_rest, shreg_next;
   logic             head_bit, next_bit;
   logic             push, pop, load, full, empty;

   // Ready comes from the registered level only, so a pop this cycle frees the slot next cycle
   assign din_ready = ~rst & ~full;
   assign push      = din_valid & din_ready;

   sync_fifo_fwft #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (din),
      .pop   (pop),
      .dout  (head),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      if (MSB_FIRST) begin
         head_bit   = head[WIDTH-1];
         head_rest  = head << 1;
         next_bit   = shreg_q[WIDTH-1];
         shreg_next = shreg_q << 1;
      end else begin
         head_bit   = head[0];
         head_rest  = head >> 1;
         next_bit   = shreg_q[0];
         shreg_next = shreg_q >> 1;
      end
   end

   // The first bit goes straight to sout on load; the shifter keeps only the remaining bits
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bitcnt_d     = bitcnt_q;
      sout_d       = sout_q;
      sout_valid_d = sout_valid_q;
      word_done_d  = 1'b0;
      load         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            load = ~empty;
         end
         ST_SHIFT: begin
            if (bitcnt_q == '0) begin
               if (!empty) begin
                  load = 1'b1;
               end else begin
                  state_d      = ST_IDLE;
                  sout_d       = IDLE_BIT;
                  sout_valid_d = 1'b0;
               end
            end else begin
               shreg_d     = shreg_next;
               sout_d      = next_bit;
               bitcnt_d    = bitcnt_q - 1'b1;
               word_done_d = (bitcnt_q == CNT_W'(1));
            end
         end
      endcase
      if (load) begin
         state_d      = ST_SHIFT;
         shreg_d      = head_rest;
         sout_d       = head_bit;
         sout_valid_d = 1'b1;
         bitcnt_d     = CNT_W'(WIDTH - 1);
      end
      pop = load;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         shreg_q      <= '0;
         bitcnt_q     <= '0;
         sout_q       <= IDLE_BIT;
         sout_valid_q <= 1'b0;
         word_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bitcnt_q     <= bitcnt_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
         word_done_q  <= word_done_d;
      end
   end

   assign sout       = sout_q;
   assign sout_valid = sout_valid_q;
   assign word_done  = word_done_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench: vector table for reset/single word, hand sequences for streaming, full, reset and LSB-first.
module tb_serial_bit_feeder;

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       sout;
   logic       sout_valid;
   logic       word_done;
   logic [2:0] level;

   logic [7:0] din_l;
   logic       din_valid_l;
   logic       din_ready_l;
   logic       sout_l;
   logic       sout_valid_l;
   logic       word_done_l;
   logic [2:0] level_l;

   serial_bit_feeder #(
      .WIDTH     (8),
      .DEPTH     (4),
      .IDLE_BIT  (1'b0),
      .MSB_FIRST (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .sout       (sout),
      .sout_valid (sout_valid),
      .word_done  (word_done),
      .level      (level)
   );

   serial_bit_feeder #(
      .WIDTH     (8),
      .DEPTH     (4),
      .IDLE_BIT  (1'b0),
      .MSB_FIRST (1'b0)
   ) dut_lsb (
      .clk        (clk),
      .rst        (rst),
      .din        (din_l),
      .din_valid  (din_valid_l),
      .din_ready  (din_ready_l),
      .sout       (sout_l),
      .sout_valid (sout_valid_l),
      .word_done  (word_done_l),
      .level      (level_l)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic       r;
      logic       v;
      logic [7:0] d;
      logic       rdy;
      logic       s;
      logic       sv;
      logic       wd;
      logic [2:0] lvl;
   } vec_t;

   vec_t tbl [15];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference occupancy/shifter model, stepped once per clock edge
   int   m_lvl  = 0;
   int   m_busy = 0;
   int   m_cnt  = 0;
   logic cur_rst, cur_v;

   logic       lsb_v;
   logic [7:0] lsb_d;
   logic       mon_en;
   bit         got_q [$];
   int         cyc_q [$];
   bit         wd_q  [$];
   logic [7:0] sent_q [$];

   function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                               input logic rdy, input logic s, input logic sv,
                               input logic wd, input logic [2:0] lvl);
      vec_t t;
      t.r = r; t.v = v; t.d = d; t.rdy = rdy; t.s = s; t.sv = sv; t.wd = wd; t.lvl = lvl;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [7:0] d);
      int mpush, mpop;
      if (cur_rst) begin
         m_lvl = 0; m_busy = 0; m_cnt = 0;
      end else begin
         mpush = (cur_v && m_lvl < 4) ? 1 : 0;
         mpop  = (m_lvl > 0 && (m_busy == 0 || m_cnt == 0)) ? 1 : 0;
         if (mpop == 1) begin
            m_busy = 1; m_cnt = 7;
         end else if (m_busy == 1) begin
            if (m_cnt == 0) m_busy = 0;
            else m_cnt = m_cnt - 1;
         end
         m_lvl = m_lvl + mpush - mpop;
      end
      @(posedge clk);
      #1;
      rst = r; din_valid = v; din = d;
      din_valid_l = lsb_v; din_l = lsb_d;
      cur_rst = r; cur_v = v;
      @(negedge clk);
      cyc++;
      chk("m_level", 32'(level), 32'(m_lvl));
      chk("m_din_ready", 32'(din_ready), 32'((!r && m_lvl < 4) ? 1 : 0));
      chk("m_sout_valid", 32'(sout_valid), 32'(m_busy));
      chk("m_word_done", 32'(word_done), 32'((m_busy == 1 && m_cnt == 0) ? 1 : 0));
      if (mon_en && sout_valid) begin
         got_q.push_back(sout);
         cyc_q.push_back(cyc);
         wd_q.push_back(word_done);
      end
   endtask

   task automatic clear_mon();
      got_q.delete();
      cyc_q.delete();
      wd_q.delete();
      sent_q.delete();
   endtask

   initial begin
      logic [7:0] w3 [4];
      logic [7:0] nxt;
      logic [7:0] word;
      logic [7:0] w5;
      logic       exp6 [8];
      int         maxl, stalled, pc;

      rst = 1'b1; din_valid = 1'b1; din = 8'hA5;
      din_valid_l = 1'b0; din_l = '0; lsb_v = 1'b0; lsb_d = '0;
      cur_rst = 1'b1; cur_v = 1'b1; mon_en = 1'b0;

      // Reset held two cycles with din_valid high, release, then single word 8'hB0
      tbl[0]  = mk(1, 1, 8'hA5, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 1, 8'hA5, 0, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 8'h00, 1, 0, 0, 0, 0);
      tbl[3]  = mk(0, 0, 8'h00, 1, 0, 0, 0, 0);
      tbl[4]  = mk(0, 1, 8'hB0, 1, 0, 0, 0, 0);
      tbl[5]  = mk(0, 0, 8'h00, 1, 0, 0, 0, 1);
      tbl[6]  = mk(0, 0, 8'h00, 1, 1, 1, 0, 0);
      tbl[7]  = mk(0, 0, 8'h00, 1, 0, 1, 0, 0);
      tbl[8]  = mk(0, 0, 8'h00, 1, 1, 1, 0, 0);
      tbl[9]  = mk(0, 0, 8'h00, 1, 1, 1, 0, 0);
      tbl[10] = mk(0, 0, 8'h00, 1, 0, 1, 0, 0);
      tbl[11] = mk(0, 0, 8'h00, 1, 0, 1, 0, 0);
      tbl[12] = mk(0, 0, 8'h00, 1, 0, 1, 0, 0);
      tbl[13] = mk(0, 0, 8'h00, 1, 0, 1, 1, 0);
      tbl[14] = mk(0, 0, 8'h00, 1, 0, 0, 0, 0);

      for (int i = 0; i < 15; i++) begin
         step(tbl[i].r, tbl[i].v, tbl[i].d);
         chk($sformatf("t_ready[%0d]", i), 32'(din_ready), 32'(tbl[i].rdy));
         chk($sformatf("t_sout[%0d]", i), 32'(sout), 32'(tbl[i].s));
         chk($sformatf("t_valid[%0d]", i), 32'(sout_valid), 32'(tbl[i].sv));
         chk($sformatf("t_done[%0d]", i), 32'(word_done), 32'(tbl[i].wd));
         chk($sformatf("t_level[%0d]", i), 32'(level), 32'(tbl[i].lvl));
      end

      // Back-to-back words: 32 contiguous bits, word_done on every 8th
      w3[0] = 8'hA5; w3[1] = 8'h3C; w3[2] = 8'hFF; w3[3] = 8'h01;
      clear_mon();
      mon_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, w3[i]);
         chk("b2b_ready", 32'(din_ready), 32'd1);
      end
      for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 8'h00);
      mon_en = 1'b0;
      chk("b2b_count", 32'(got_q.size()), 32'd32);
      for (int k = 0; k < got_q.size() && k < 32; k++) begin
         word = w3[k / 8];
         chk($sformatf("b2b_bit[%0d]", k), 32'(got_q[k]), 32'(word[7 - (k % 8)]));
         chk($sformatf("b2b_gap[%0d]", k), 32'(cyc_q[k]), 32'(cyc_q[0] + k));
         chk($sformatf("b2b_done[%0d]", k), 32'(wd_q[k]), 32'((k % 8 == 7) ? 1 : 0));
      end

      // Saturate the buffer with incrementing words; every word must come out once, in order
      clear_mon();
      mon_en = 1'b1;
      nxt = 8'h40; maxl = 0; stalled = 0;
      for (int c = 0; c < 300 && sent_q.size() < 10; c++) begin
         step(1'b0, 1'b1, nxt);
         if (int'(level) > maxl) maxl = int'(level);
         if (!din_ready) stalled = 1;
         if (din_ready) begin
            sent_q.push_back(nxt);
            nxt = nxt + 8'd1;
         end
      end
      chk("full_sent", 32'(sent_q.size()), 32'd10);
      for (int c = 0; c < 200 && got_q.size() < 80; c++) step(1'b0, 1'b0, 8'h00);
      for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 8'h00);
      mon_en = 1'b0;
      chk("full_drain_bits", 32'(got_q.size()), 32'd80);
      chk("full_max_level", 32'(maxl), 32'd4);
      chk("full_stalled", 32'(stalled), 32'd1);
      for (int w = 0; w < got_q.size() / 8 && w < sent_q.size(); w++) begin
         for (int b = 0; b < 8; b++) word[7 - b] = got_q[w * 8 + b];
         chk($sformatf("full_word[%0d]", w), 32'(word), 32'(sent_q[w]));
      end

      // Reset during a word with two more buffered, then a fresh word
      step(1'b0, 1'b1, 8'hF0);
      step(1'b0, 1'b1, 8'h11);
      step(1'b0, 1'b1, 8'h22);
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      chk("rst_mid_valid_before", 32'(sout_valid), 32'd1);
      step(1'b1, 1'b0, 8'h00);
      chk("rst_mid_ready_in_rst", 32'(din_ready), 32'd0);
      chk("rst_mid_level_before", 32'(level), 32'd2);
      step(1'b0, 1'b0, 8'h00);
      chk("rst_mid_sout", 32'(sout), 32'd0);
      chk("rst_mid_valid", 32'(sout_valid), 32'd0);
      chk("rst_mid_level", 32'(level), 32'd0);
      clear_mon();
      mon_en = 1'b1;
      step(1'b0, 1'b1, 8'h0F);
      pc = cyc;
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'h00);
      mon_en = 1'b0;
      chk("rst_new_count", 32'(got_q.size()), 32'd8);
      w5 = 8'h0F;
      for (int k = 0; k < got_q.size() && k < 8; k++) begin
         chk($sformatf("rst_new_bit[%0d]", k), 32'(got_q[k]), 32'(w5[7 - k]));
         chk($sformatf("rst_new_done[%0d]", k), 32'(wd_q[k]), 32'((k == 7) ? 1 : 0));
      end
      if (cyc_q.size() > 0) chk("rst_new_latency", 32'(cyc_q[0]), 32'(pc + 2));

      // LSB-first instance: 8'h0D goes out as 1,0,1,1,0,0,0,0
      exp6 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      lsb_v = 1'b1; lsb_d = 8'h0D;
      step(1'b0, 1'b0, 8'h00);
      lsb_v = 1'b0; lsb_d = 8'h00;
      step(1'b0, 1'b0, 8'h00);
      chk("lsb_level", 32'(level_l), 32'd1);
      chk("lsb_idle_valid", 32'(sout_valid_l), 32'd0);
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b0, 8'h00);
         chk($sformatf("lsb_bit[%0d]", k), 32'(sout_l), 32'(exp6[k]));
         chk($sformatf("lsb_valid[%0d]", k), 32'(sout_valid_l), 32'd1);
         chk($sformatf("lsb_done[%0d]", k), 32'(word_done_l), 32'((k == 7) ? 1 : 0));
      end
      step(1'b0, 1'b0, 8'h00);
      chk("lsb_end_valid", 32'(sout_valid_l), 32'd0);
      chk("lsb_end_sout", 32'(sout_l), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
